modulator_3lpd: RTL
===================

Name: modulator_3lpd

Overview:
- Three-level phase-disposition (PD) carrier PWM modulator. It produces the 2-bit voltage-level command v_lev consumed by the 3L NPC/NPP/ANPC switching decoders.
- It compares a signed, shadow-latched reference against two level-shifted triangular carriers built from one up/down counter.
- Transitions are limited to adjacent levels, so the decoders never see a 0↔2 jump.
- Sits between the AXI register bank (reference, period, enable) and the decoder's v_lev input.

Parameters:
- CNT_WIDTH, 16, width of carrier counter and period.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  modulator enable
- period  in  CNT_WIDTH  carrier half-period P in clocks (unsigned)
- m_ref  in  CNT_WIDTH+1  signed reference, nominal range [-P, +P]
- v_lev  out  2  level command: 2'b00 negative, 2'b01 zero, 2'b10 positive (2'b11 never driven)
- carrier  out  CNT_WIDTH  current counter value c
- dir  out  1  counter direction: 1 up, 0 down
- sample_tick  out  1  one-clock pulse when the reference is latched (peak or valley)

Behaviour:
- Reset (async, rst=1) values:
  - c=0, dir=1, v_lev=2'b01, sample_tick=0.
  - ref_sh=0, P_sh=2.
- en=0 (synchronous):
  - c held at 0, dir=1, v_lev forced 2'b01 next clock, sample_tick=0.
  - ref_sh and P_sh keep their values.
- en rising: the first enabled clock is treated as a valley.
  - Latch P_sh and ref_sh, pulse sample_tick.
  - c goes 0→1 on the following clock.
- Counter, when enabled:
  - dir=1 and c==P_sh: c<=c-1, dir<=0 (peak).
  - dir=0 and c==0: c<=c+1, dir<=1 (valley).
  - Otherwise c steps ±1 per dir.
  - Peak and valley each last exactly one clock; carrier period is 2·P_sh clocks.
- Period shadow:
  - period is sampled into P_sh only at a valley (c==0).
  - Values <2 are latched as 2.
  - A change mid-period has no effect until the next valley.
- Reference shadow:
  - m_ref is sampled at every peak (c==P_sh, dir=1) and every valley (c==0), with sample_tick=1 in that same clock.
  - It is saturated to [-P_sh, +P_sh], using the P_sh value in effect after any same-clock valley update.
  - The new ref_sh is used by comparisons from the next clock.
- Level target, computed from the current c and ref_sh:
  - tgt=2'b10 if ref_sh > c.
  - tgt=2'b00 if ref_sh < c − P_sh (signed compare, CNT_WIDTH+1 bits, no overflow).
  - tgt=2'b01 otherwise.
- Output (registered, 1-clock latency from carrier):
  - If tgt differs from v_lev by two levels (00↔10), v_lev<=2'b01 for exactly one clock, then the next clock's tgt applies.
  - Otherwise v_lev<=tgt.
- Simultaneous events:
  - en falling has priority over peak/valley handling.
  - rst has priority over everything.
- Reset mid-period: the counter restarts from the valley state. There is no partial-period output.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst mid-count with en=1, release with en=0.
  - Required: v_lev=01, carrier=0, dir=1, sample_tick=0 held indefinitely.
- Zero reference:
  - Stimulus: P=4, m_ref=0, en=1.
  - Required: carrier sequence 0,1,2,3,4,3,2,1 repeating; v_lev constant 01; sample_tick high at c=0 and c=4.
- Positive reference:
  - Stimulus: P=4, m_ref=+2 held.
  - Required: after first latch, v_lev=10 for exactly 3 of every 8 clocks (c∈{0,1,1}), else 01; never 00.
- Saturation:
  - Stimulus: P=4, m_ref=+9.
  - Required: ref_sh=+4; v_lev=10 except one clock of 01 per period (after c=4).
  - Mirror stimulus: m_ref=−9 gives 00 except one clock of 01 per period (after c=0).
- Adjacent-step rule:
  - Stimulus: P=4, m_ref=−4 until a peak, then +4.
  - Required: v_lev goes 00→01 (one clock)→10; never 00→10 directly.
- Period shadow:
  - Stimulus: change period 4→6 while c=2, dir=1.
  - Required: current period completes with peak at 4; the next period peaks at 6.
  - Stimulus: period=1.
  - Required: P_sh=2.

Source files
------------

// File: rtl/modulator_3lpd_if.sv
// Bus between the register bank / stimulus side (master) and the
// three-level PD modulator (slave).
interface modulator_3lpd_if #(
  parameter int CNT_WIDTH = 16
);
  logic                        en;
  logic [CNT_WIDTH-1:0]        period;
  logic signed [CNT_WIDTH:0]   m_ref;
  logic [1:0]                  v_lev;
  logic [CNT_WIDTH-1:0]        carrier;
  logic                        dir;
  logic                        sample_tick;

  modport master (
    output en, period, m_ref,
    input  v_lev, carrier, dir, sample_tick
  );

  modport slave (
    input  en, period, m_ref,
    output v_lev, carrier, dir, sample_tick
  );
endinterface

// File: rtl/modulator_3lpd.sv
// Three-level phase-disposition PWM modulator. One up/down counter forms
// both level-shifted carriers: the upper carrier is c, the lower one c-P.
// The reference and half-period are shadowed at peak/valley so that a
// period always completes with the values it started with, and the level
// output only ever moves between adjacent levels.
module modulator_3lpd #(
  parameter int CNT_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  modulator_3lpd_if.slave bus
);

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  localparam logic [CNT_WIDTH-1:0] P_MIN    = CNT_WIDTH'(2);
  localparam logic [1:0]           LEV_NEG  = 2'b00;
  localparam logic [1:0]           LEV_ZERO = 2'b01;
  localparam logic [1:0]           LEV_POS  = 2'b10;

  logic [CNT_WIDTH-1:0]      r_cnt, w_cnt_next;
  dir_t                      r_dir, w_dir_next;
  logic [1:0]                r_v_lev, w_v_lev_next;
  logic signed [CNT_WIDTH:0] r_ref_sh, w_ref_sh_next;
  logic [CNT_WIDTH-1:0]      r_p_sh, w_p_sh_next;

  logic                      w_valley;
  logic                      w_peak;
  logic                      w_sample;
  logic [CNT_WIDTH-1:0]      w_period_clamped;
  logic [CNT_WIDTH-1:0]      w_p_eff;
  logic signed [CNT_WIDTH:0] w_p_lim;
  logic signed [CNT_WIDTH:0] w_ref_sat;
  logic signed [CNT_WIDTH:0] w_cnt_s;
  logic signed [CNT_WIDTH:0] w_low_thr;
  logic [1:0]                w_tgt;
  logic                      w_two_step;

  // A valley is any clock with c==0; this also covers the first enabled
  // clock after idle, where dir is still up.
  assign w_valley = (r_cnt == '0);
  assign w_peak   = (r_dir == DIR_UP) && (r_cnt == r_p_sh);
  assign w_sample = bus.en && (w_valley || w_peak);

  // Half-periods below 2 would collapse peak onto valley.
  assign w_period_clamped = (bus.period < P_MIN) ? P_MIN : bus.period;

  // The saturation limit must see a half-period updated in this same clock.
  assign w_p_eff = (bus.en && w_valley) ? w_period_clamped : r_p_sh;
  assign w_p_lim = $signed({1'b0, w_p_eff});

  // Clamp the incoming reference to [-P, +P].
  always_comb begin
    w_ref_sat = bus.m_ref;
    if (bus.m_ref > w_p_lim) begin
      w_ref_sat = w_p_lim;
    end else if (bus.m_ref < -w_p_lim) begin
      w_ref_sat = -w_p_lim;
    end
  end

  // One extra bit keeps c - P_sh exact over the full counter range.
  assign w_cnt_s   = $signed({1'b0, r_cnt});
  assign w_low_thr = w_cnt_s - $signed({1'b0, r_p_sh});

  // Level target from comparing the reference against both carriers.
  always_comb begin
    w_tgt = LEV_ZERO;
    if (r_ref_sh > w_cnt_s) begin
      w_tgt = LEV_POS;
    end else if (r_ref_sh < w_low_thr) begin
      w_tgt = LEV_NEG;
    end
  end

  assign w_two_step = ((r_v_lev == LEV_NEG) && (w_tgt == LEV_POS)) ||
                      ((r_v_lev == LEV_POS) && (w_tgt == LEV_NEG));

  // Next-state: counter/direction walk, shadow latching and output level.
  always_comb begin
    w_cnt_next    = r_cnt;
    w_dir_next    = r_dir;
    w_v_lev_next  = r_v_lev;
    w_ref_sh_next = r_ref_sh;
    w_p_sh_next   = r_p_sh;
    if (!bus.en) begin
      w_cnt_next   = '0;
      w_dir_next   = DIR_UP;
      w_v_lev_next = LEV_ZERO;
    end else begin
      w_v_lev_next = w_two_step ? LEV_ZERO : w_tgt;
      if (w_valley) begin
        w_p_sh_next = w_period_clamped;
      end
      if (w_sample) begin
        w_ref_sh_next = w_ref_sat;
      end
      unique case (r_dir)
        DIR_UP: begin
          if (w_peak) begin
            w_cnt_next = r_cnt - CNT_WIDTH'(1);
            w_dir_next = DIR_DOWN;
          end else begin
            w_cnt_next = r_cnt + CNT_WIDTH'(1);
          end
        end
        DIR_DOWN: begin
          if (w_valley) begin
            w_cnt_next = r_cnt + CNT_WIDTH'(1);
            w_dir_next = DIR_UP;
          end else begin
            w_cnt_next = r_cnt - CNT_WIDTH'(1);
          end
        end
        default: begin
          w_cnt_next = '0;
          w_dir_next = DIR_UP;
        end
      endcase
    end
  end

  // State registers; reset restarts from the valley with a zero output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dir    <= DIR_UP;
      r_v_lev  <= LEV_ZERO;
      r_ref_sh <= '0;
      r_p_sh   <= P_MIN;
    end else begin
      r_cnt    <= w_cnt_next;
      r_dir    <= w_dir_next;
      r_v_lev  <= w_v_lev_next;
      r_ref_sh <= w_ref_sh_next;
      r_p_sh   <= w_p_sh_next;
    end
  end

  assign bus.v_lev       = r_v_lev;
  assign bus.carrier     = r_cnt;
  assign bus.dir         = r_dir;
  assign bus.sample_tick = w_sample & ~rst;

endmodule
